// File: rtl/wb_exmem_bram_ctrl_if.sv
// Wishbone classic slave-side bus bundle for the exmem BRAM controller.
// The master drives cycle/strobe/address/data and the slave returns ack and read data.
interface wb_exmem_bram_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_exmem_bram_ctrl.sv
// Wishbone slave in front of the FIR-lab BRAM: programmable wait, then one
// single-cycle BRAM access and a single-cycle ack, emulating slow memory.
module wb_exmem_bram_ctrl #(
    parameter int         DELAYS    = 10,
    parameter int         ADDR_BITS = 7,
    parameter logic [7:0] BASE_HI   = 8'h38
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_exmem_bram_ctrl_if.slave  wbs,
    output logic                 bram_en,
    output logic [3:0]           bram_we,
    output logic [ADDR_BITS-1:0] bram_a,
    output logic [31:0]          bram_di,
    input  logic [31:0]          bram_do
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_CAPTURE,
        S_ACK
    } state_t;

    localparam logic [7:0] LAST = 8'(DELAYS - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        we_l;
    logic [3:0]  sel_l;
    logic        en_q;
    logic [3:0]  we_q;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        live;
    logic        hit;

    assign live = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign hit  = live & (wbs.wbs_adr_i[31:24] == BASE_HI);

    // Reset must kill an access even in the cycle it would reach the BRAM.
    assign bram_en       = en_q & ~wb_rst_i;
    assign bram_we       = we_q & {4{~wb_rst_i}};
    assign wbs.wbs_ack_o = ack_q & wbs.wbs_cyc_i;
    assign wbs.wbs_dat_o = dat_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_l    <= 1'b0;
            sel_l   <= '0;
            en_q    <= 1'b0;
            we_q    <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            bram_a  <= '0;
            bram_di <= '0;
        end else begin
            en_q  <= 1'b0;
            we_q  <= '0;
            ack_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (hit) begin
                        we_l    <= wbs.wbs_we_i;
                        sel_l   <= wbs.wbs_sel_i;
                        bram_di <= wbs.wbs_dat_i;
                        bram_a  <= wbs.wbs_adr_i[ADDR_BITS+1:2];
                        cnt     <= '0;
                        if (DELAYS == 0) begin
                            state <= S_ACCESS;
                            en_q  <= 1'b1;
                            we_q  <= wbs.wbs_we_i ? wbs.wbs_sel_i : 4'b0000;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (!live) begin
                        state <= S_IDLE;
                    end else if (cnt == LAST) begin
                        state <= S_ACCESS;
                        en_q  <= 1'b1;
                        we_q  <= we_l ? sel_l : 4'b0000;
                    end
                end
                S_ACCESS: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!we_l) dat_q <= bram_do;
                    state <= S_ACK;
                    ack_q <= 1'b1;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_exmem_bram_ctrl.sv
// Bench for wb_exmem_bram_ctrl: a DELAYS=10 and a DELAYS=0 instance, each
// with its own BRAM model, checked against a word-array memory model.
module tb_wb_exmem_bram_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        cyc    [2];
    logic        stb    [2];
    logic        we_i   [2];
    logic [3:0]  sel_i  [2];
    logic [31:0] adr_i  [2];
    logic [31:0] dat_i  [2];
    logic        ack    [2];
    logic [31:0] dato   [2];
    logic        en     [2];
    logic [3:0]  bwe    [2];
    logic [6:0]  ba     [2];
    logic [31:0] bdi    [2];
    logic [31:0] bdo    [2];
    logic [31:0] mem    [2][128];
    logic        mem_clr;

    logic [31:0] refm   [2][128];
    logic [31:0] last_rd[2];
    int          dly    [2];
    int          en_cnt [2];
    int          ack_cnt[2];
    int          dbl_ack;
    logic        pack   [2];
    int          vectors;
    int          errors;

    wb_exmem_bram_ctrl_if if0 ();
    wb_exmem_bram_ctrl_if if1 ();

    assign if0.wbs_cyc_i = cyc[0];
    assign if0.wbs_stb_i = stb[0];
    assign if0.wbs_we_i  = we_i[0];
    assign if0.wbs_sel_i = sel_i[0];
    assign if0.wbs_adr_i = adr_i[0];
    assign if0.wbs_dat_i = dat_i[0];
    assign ack[0]        = if0.wbs_ack_o;
    assign dato[0]       = if0.wbs_dat_o;
    assign if1.wbs_cyc_i = cyc[1];
    assign if1.wbs_stb_i = stb[1];
    assign if1.wbs_we_i  = we_i[1];
    assign if1.wbs_sel_i = sel_i[1];
    assign if1.wbs_adr_i = adr_i[1];
    assign if1.wbs_dat_i = dat_i[1];
    assign ack[1]        = if1.wbs_ack_o;
    assign dato[1]       = if1.wbs_dat_o;

    wb_exmem_bram_ctrl #(.DELAYS(10), .ADDR_BITS(7), .BASE_HI(8'h38)) u_dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst[0]),
        .wbs      (if0),
        .bram_en  (en[0]),
        .bram_we  (bwe[0]),
        .bram_a   (ba[0]),
        .bram_di  (bdi[0]),
        .bram_do  (bdo[0])
    );

    wb_exmem_bram_ctrl #(.DELAYS(0), .ADDR_BITS(7), .BASE_HI(8'h38)) u_dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst[1]),
        .wbs      (if1),
        .bram_en  (en[1]),
        .bram_we  (bwe[1]),
        .bram_a   (ba[1]),
        .bram_di  (bdi[1]),
        .bram_do  (bdo[1])
    );

    // BRAM: byte-lane writes, registered read data, zero after an idle cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_clr) begin
                for (int i = 0; i < 128; i++) mem[k][i] <= '0;
                bdo[k] <= '0;
            end else if (en[k]) begin
                for (int b = 0; b < 4; b++)
                    if (bwe[k][b]) mem[k][ba[k]][8*b +: 8] <= bdi[k][8*b +: 8];
                bdo[k] <= mem[k][ba[k]];
            end else begin
                bdo[k] <= '0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (en[k]) en_cnt[k]++;
            if (ack[k]) ack_cnt[k]++;
            if (ack[k] && pack[k]) dbl_ack++;
            pack[k] = ack[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int k, input logic w, input logic [31:0] adr,
                        input logic [31:0] d, input logic [3:0] s,
                        output int ack_c, output int en_c, output int en_n,
                        output logic [3:0] e_we, output logic [6:0] e_a,
                        output logic [31:0] e_di, output logic [31:0] rd);
        @(posedge clk); #1;
        cyc[k] = 1'b1; stb[k] = 1'b1; we_i[k] = w;
        adr_i[k] = adr; dat_i[k] = d; sel_i[k] = s;
        ack_c = -1; en_c = -1; en_n = 0;
        e_we = 'x; e_a = 'x; e_di = 'x; rd = 'x;
        for (int c = 0; c < 64 && ack_c < 0; c++) begin
            @(negedge clk);
            if (en[k]) begin
                en_n++;
                if (en_c < 0) begin
                    en_c = c; e_we = bwe[k]; e_a = ba[k]; e_di = bdi[k];
                end
            end
            if (ack[k]) begin
                ack_c = c; rd = dato[k];
            end
        end
        @(posedge clk); #1;
        cyc[k] = 1'b0; stb[k] = 1'b0;
    endtask

    task automatic do_xfer(input int k, input logic w, input logic [31:0] adr,
                           input logic [31:0] d, input logic [3:0] s, input string tag);
        int ac, ec, nn, wd;
        logic [3:0]  ewe;
        logic [6:0]  ea;
        logic [31:0] edi, rd;
        wd = int'((adr >> 2) % 32'd128);
        xfer(k, w, adr, d, s, ac, ec, nn, ewe, ea, edi, rd);
        chk({tag, "/ack_cycle"}, ac, dly[k] + 3);
        chk({tag, "/en_count"}, nn, 1);
        chk({tag, "/en_cycle"}, ec, dly[k] + 1);
        chk({tag, "/bram_a"}, 32'(ea), wd);
        chk({tag, "/bram_we"}, 32'(ewe), w ? 32'(s) : 32'd0);
        if (w) begin
            chk({tag, "/bram_di"}, edi, d);
            chk({tag, "/dat_o_hold"}, rd, last_rd[k]);
            for (int b = 0; b < 4; b++)
                if (s[b]) refm[k][wd][8*b +: 8] = d[8*b +: 8];
        end else begin
            chk({tag, "/rdata"}, rd, refm[k][wd]);
            last_rd[k] = refm[k][wd];
        end
    endtask

    task automatic chk_reset(input int k, input string tag);
        chk({tag, "/ack"}, 32'(ack[k]), 0);
        chk({tag, "/dat_o"}, dato[k], 0);
        chk({tag, "/en"}, 32'(en[k]), 0);
        chk({tag, "/we"}, 32'(bwe[k]), 0);
        chk({tag, "/a"}, 32'(ba[k]), 0);
        chk({tag, "/di"}, bdi[k], 0);
    endtask

    initial begin
        int e0, a0;
        logic [31:0] ra;
        vectors = 0; errors = 0; dbl_ack = 0;
        dly[0] = 10; dly[1] = 0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we_i[k] = 1'b0;
            sel_i[k] = '0; adr_i[k] = '0; dat_i[k] = '0;
            en_cnt[k] = 0; ack_cnt[k] = 0; pack[k] = 1'b0; last_rd[k] = '0;
            for (int i = 0; i < 128; i++) refm[k][i] = '0;
        end
        mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");

        do_xfer(0, 1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, "wr_w4");
        do_xfer(0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, "rd_w4");
        chk("rd_w4_const", last_rd[0], 32'hDEAD_BEEF);

        do_xfer(0, 1'b1, 32'h3800_0014, 32'h1122_3344, 4'hF, "pre_w5");
        do_xfer(0, 1'b1, 32'h3800_0014, 32'hAABB_CCDD, 4'b0100, "lane_w5");
        do_xfer(0, 1'b0, 32'h3800_0014, 32'h0, 4'hF, "rd_w5");
        chk("rd_w5_const", last_rd[0], 32'h11BB_3344);

        do_xfer(0, 1'b1, 32'h3800_0020, 32'h0F0F_0F0F, 4'hF, "pre_w8");
        e0 = en_cnt[0]; a0 = ack_cnt[0];
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we_i[0] = 1'b1;
        adr_i[0] = 32'h3800_0020; dat_i[0] = 32'hFFFF_FFFF; sel_i[0] = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        repeat (20) @(posedge clk);
        chk("abort/en", en_cnt[0] - e0, 0);
        chk("abort/ack", ack_cnt[0] - a0, 0);
        do_xfer(0, 1'b0, 32'h3800_0020, 32'h0, 4'hF, "abort_rd_w8");

        do_xfer(0, 1'b1, 32'h3800_0024, 32'h5A5A_5A5A, 4'hF, "pre_w9");
        e0 = en_cnt[0];
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we_i[0] = 1'b1;
        adr_i[0] = 32'h3800_0024; dat_i[0] = 32'hCAFE_F00D; sel_i[0] = 4'hF;
        repeat (6) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset(0, "midrst");
        rst[0] = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        last_rd[0] = '0;
        chk("midrst/en", en_cnt[0] - e0, 0);
        do_xfer(0, 1'b0, 32'h3800_0024, 32'h0, 4'hF, "midrst_rd_w9");

        e0 = en_cnt[0]; a0 = ack_cnt[0];
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we_i[0] = 1'b1;
        adr_i[0] = 32'h3000_0000; dat_i[0] = 32'h1234_5678; sel_i[0] = 4'hF;
        repeat (50) @(posedge clk);
        #1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        chk("decode/en", en_cnt[0] - e0, 0);
        chk("decode/ack", ack_cnt[0] - a0, 0);
        do_xfer(0, 1'b1, 32'h3800_0200, 32'h7777_0000, 4'hF, "wrap_w0");

        do_xfer(1, 1'b0, 32'h3800_000C, 32'h0, 4'hF, "d0_rd1");
        do_xfer(1, 1'b1, 32'h3800_000C, 32'h1234_5678, 4'hF, "d0_wr");
        do_xfer(1, 1'b0, 32'h3800_000C, 32'h0, 4'hF, "d0_rd2");
        chk("d0_rd2_const", last_rd[1], 32'h1234_5678);

        for (int n = 0; n < 40; n++) begin
            int k;
            logic w;
            k = n % 2;
            w = 1'($urandom_range(0, 1));
            ra = {8'h38, 15'($urandom), 7'($urandom_range(0, 7)), 2'($urandom)};
            do_xfer(k, w, ra, $urandom, 4'($urandom), "rand");
        end

        chk("no_double_ack", dbl_ack, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
